// File: rtl/bus_pkg.sv
// Shared bus definitions: region codes, access sizes, LSU state encoding and
// the request legality check used at the handshake.
package bus_pkg;

  // Decoder regions, taken from addr[31:20].
  localparam logic [11:0] REG_DRAM = 12'h001;
  localparam logic [11:0] REG_LED  = 12'h002;
  localparam logic [11:0] REG_SEG  = 12'h003;
  localparam logic [11:0] REG_VGA  = 12'h004;

  // Width of the wait-state counter; wide enough for any sensible WAIT value.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // True when a request must be rejected without a bus cycle: unmapped
  // region, illegal size, or an address not aligned to the access size.
  function automatic logic access_error(input logic [11:0] region,
                                        input logic [1:0]  off,
                                        input logic [1:0]  size);
    logic bad;
    bad = !(region inside {REG_DRAM, REG_LED, REG_SEG, REG_VGA});
    case (size)
      SZ_BYTE: ;
      SZ_HALF: if (off[0])       bad = 1'b1;
      SZ_WORD: if (off != 2'b00) bad = 1'b1;
      default:                   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: lane enables and store-data replication on
// the way out, shift and sign/zero extension of read data on the way in.
// Purely combinational.
module lsu_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [15:0] lane;

  // Move the addressed byte/half down to bit 0 before extension.
  assign lane = 16'(bus_rdata >> {off, 3'b000});

  // Lane enables, replicated store data and extended load data per size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    sel       = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    case (size)
      SZ_BYTE: begin
        sel       = 4'(4'b0001 << off);
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{is_signed & lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        sel       = 4'(4'b0011 << off);
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{is_signed & lane[15]}}, lane[15:0]};
      end
      SZ_WORD: begin
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = bus_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_master_lsu.sv
// CPU load/store initiator for the system bus. Takes one request at a time,
// holds the bus for a region-dependent number of wait cycles, then returns a
// one-cycle response. Bad requests skip the bus and respond with an error.
module bus_master_lsu
  import bus_pkg::*;
#(
  parameter int DRAM_WAIT   = 2,
  parameter int PERIPH_WAIT = 1
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        bus_en,
  output logic        bus_rw,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] DRAM_INIT   = CNT_W'(DRAM_WAIT - 1);
  localparam logic [CNT_W-1:0] PERIPH_INIT = CNT_W'(PERIPH_WAIT - 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q, wdata_q, rdata_q;

  logic              handshake, req_err;
  logic [CNT_W-1:0]  cnt_init;
  logic [3:0]        lane_sel;
  logic [31:0]       lane_wdata, lane_rdata;

  assign req_ready = (state == IDLE) && !rst;
  assign handshake = req && req_ready;
  assign req_err   = access_error(req_addr[31:20], req_addr[1:0], req_size);
  assign cnt_init  = (req_addr[31:20] == REG_DRAM) ? DRAM_INIT : PERIPH_INIT;

  lsu_lane_align u_align (
    .size      (size_q),
    .off       (addr_q[1:0]),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .bus_rdata (bus_rdata),
    .sel       (lane_sel),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge sck) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: error requests bypass the bus and go straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = req_err ? DONE : ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait-state counting and read-data capture.
  always_ff @(posedge sck) begin
    // NOTE: the datapath registers are reset too, so no stale request or data survives rst.
    if (rst) begin
      cnt      <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else if (handshake) begin
      cnt      <= req_err ? '0 : cnt_init;
      we_q     <= req_we;
      signed_q <= req_signed;
      err_q    <= req_err;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'h0;
    end else if (state == ACCESS) begin
      if (cnt == '0) rdata_q <= we_q ? 32'h0 : lane_rdata;
      else           cnt     <= cnt - 1'b1;
    end
  end

  // Outputs decoded from registered state and fields only; bus idles at zero.
  always_comb begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    bus_en     = 1'b0;
    bus_rw     = 1'b0;
    bus_sel    = 4'b0000;
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;
    case (state)
      ACCESS: begin
        bus_en    = 1'b1;
        bus_rw    = we_q;
        bus_sel   = lane_sel;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_wdata = lane_wdata;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule
